// File: rtl/cini_ctrl_pkg.sv
// Shared types and constants for the CINI masked-AND sequencer.
package cini_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REF  = 3'd1,
    MUL  = 3'd2,
    CAP  = 3'd3,
    HOLD = 3'd4
  } state_t;

  // Copies per share bit; majority decode assumes exactly three.
  localparam int REP_C = 3;

  // Bit positions inside the PRNG word.
  localparam int RND_REF = 0;
  localparam int RND_MUL = 1;

  // Two-out-of-three majority vote.
  function automatic logic maj3(input logic [REP_C-1:0] x);
    return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
  endfunction

endpackage

// File: rtl/cini_rep_check.sv
// Majority decode and disagreement detection for one triplicated share.
module cini_rep_check
  import cini_ctrl_pkg::*;
(
  input  logic [REP_C-1:0] rep,
  output logic             maj,
  output logic             mismatch
);

  assign maj      = maj3(rep);
  // Copies disagree when they are neither all ones nor all zeros.
  assign mismatch = (|rep) & ~(&rep);

endmodule

// File: rtl/cini_mul_sequencer.sv
// Drives one first-order masked AND through the triplicated HPC1 gadget:
// b shares with refresh randomness first, a shares with multiplication
// randomness next, then captures and majority-decodes the result shares.
module cini_mul_sequencer
  import cini_ctrl_pkg::*;
#(
  parameter int REP        = 3,
  parameter int CNT_W      = 4,
  parameter bit FAULT_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a_0,
  input  logic             in_a_1,
  input  logic             in_b_0,
  input  logic             in_b_1,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  input  logic [1:0]       rnd_data,
  output logic [REP-1:0]   gad_a_0,
  output logic [REP-1:0]   gad_a_1,
  output logic [REP-1:0]   gad_b_0,
  output logic [REP-1:0]   gad_b_1,
  output logic             gad_rand_ref,
  output logic             gad_rand_mul,
  input  logic [REP-1:0]   gad_c_0,
  input  logic [REP-1:0]   gad_c_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_c_0,
  output logic             out_c_1,
  output logic             fault,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             busy
);

  state_t state;

  // Operand/randomness held between accept and the MUL cycle. Each share
  // lives in its own register and never meets the other share here.
  logic a_0_p0;
  logic a_1_p0;
  logic rnd_mul_p0;

  logic maj_0, maj_1;
  logic mismatch_0, mismatch_1;
  logic mismatch_any;
  logic accept;
  logic zero_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_ready  = (state == IDLE) & rnd_valid;
  assign rnd_ready = (state == IDLE) & in_valid;
  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) & in_valid & rnd_valid;

  cini_rep_check u_chk_0 (
    .rep      (gad_c_0),
    .maj      (maj_0),
    .mismatch (mismatch_0)
  );

  cini_rep_check u_chk_1 (
    .rep      (gad_c_1),
    .maj      (maj_1),
    .mismatch (mismatch_1)
  );

  assign mismatch_any = mismatch_0 | mismatch_1;
  // Once a fault is seen (earlier or in this capture) results are suppressed.
  assign zero_out     = FAULT_ZERO & (fault | mismatch_any);

  // Capture a shares and multiplication randomness on accept (data only).
  always_ff @(posedge clk) begin
    if (accept) begin
      a_0_p0     <= in_a_0;
      a_1_p0     <= in_a_1;
      rnd_mul_p0 <= rnd_data[RND_MUL];
    end
  end

  // Sequencing FSM with registered gadget drive and result buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      gad_a_0      <= '0;
      gad_a_1      <= '0;
      gad_b_0      <= '0;
      gad_b_1      <= '0;
      gad_rand_ref <= 1'b0;
      gad_rand_mul <= 1'b0;
      out_valid    <= 1'b0;
      out_c_0      <= 1'b0;
      out_c_1      <= 1'b0;
      fault        <= 1'b0;
      fault_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= REF;
            gad_b_0      <= {REP{in_b_0}};
            gad_b_1      <= {REP{in_b_1}};
            gad_rand_ref <= rnd_data[RND_REF];
          end
        end
        REF: begin
          state        <= MUL;
          gad_b_0      <= '0;
          gad_b_1      <= '0;
          gad_rand_ref <= 1'b0;
          gad_a_0      <= {REP{a_0_p0}};
          gad_a_1      <= {REP{a_1_p0}};
          gad_rand_mul <= rnd_mul_p0;
        end
        MUL: begin
          state        <= CAP;
          gad_a_0      <= '0;
          gad_a_1      <= '0;
          gad_rand_mul <= 1'b0;
        end
        CAP: begin
          state     <= HOLD;
          out_valid <= 1'b1;
          out_c_0   <= zero_out ? 1'b0 : maj_0;
          out_c_1   <= zero_out ? 1'b0 : maj_1;
          if (mismatch_any) begin
            fault     <= 1'b1;
            fault_cnt <= sat_inc(fault_cnt);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          gad_a_0      <= '0;
          gad_a_1      <= '0;
          gad_b_0      <= '0;
          gad_b_1      <= '0;
          gad_rand_ref <= 1'b0;
          gad_rand_mul <= 1'b0;
          out_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cini_mul_sequencer.sv
// Bench for cini_mul_sequencer with a behavioural HPC1 gadget model.
module tb_cini_mul_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_a_0, in_a_1, in_b_0, in_b_1;
  logic rnd_valid, out_ready;
  logic [1:0] rnd_data;

  logic in_ready, rnd_ready, out_valid, out_c_0, out_c_1, fault, busy;
  logic [2:0] gad_a_0, gad_a_1, gad_b_0, gad_b_1;
  logic gad_rand_ref, gad_rand_mul;
  logic [3:0] fault_cnt;

  logic z_in_ready, z_rnd_ready, z_out_valid, z_out_c_0, z_out_c_1, z_fault, z_busy;
  logic [2:0] z_gad_a_0, z_gad_a_1, z_gad_b_0, z_gad_b_1;
  logic z_gad_rand_ref, z_gad_rand_mul;
  logic [3:0] z_fault_cnt;

  logic [2:0] gc0, gc1;
  logic [13:0] gbus, zbus;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic tb_fault = 1'b0;
  int tb_cnt = 0;
  logic inj = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // HPC1 gadget model: refresh b in the first stage, multiply in the second.
  logic [2:0] br0 = '0, br1 = '0, c0r = '0, c1r = '0;
  always @(posedge clk) begin
    br0 <= gad_b_0 ^ {3{gad_rand_ref}};
    br1 <= gad_b_1 ^ {3{gad_rand_ref}};
    c0r <= (gad_a_0 & br0) ^ ((gad_a_0 & br1) ^ {3{gad_rand_mul}});
    c1r <= (gad_a_1 & br1) ^ ((gad_a_1 & br0) ^ {3{gad_rand_mul}});
  end
  assign gc0 = c0r ^ {1'b0, inj, 1'b0};
  assign gc1 = c1r;

  assign gbus = {gad_a_0, gad_a_1, gad_b_0, gad_b_1, gad_rand_ref, gad_rand_mul};
  assign zbus = {z_gad_a_0, z_gad_a_1, z_gad_b_0, z_gad_b_1, z_gad_rand_ref, z_gad_rand_mul};

  cini_mul_sequencer #(.REP(3), .CNT_W(4), .FAULT_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_0(in_a_0), .in_a_1(in_a_1), .in_b_0(in_b_0), .in_b_1(in_b_1),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .gad_a_0(gad_a_0), .gad_a_1(gad_a_1), .gad_b_0(gad_b_0), .gad_b_1(gad_b_1),
    .gad_rand_ref(gad_rand_ref), .gad_rand_mul(gad_rand_mul),
    .gad_c_0(gc0), .gad_c_1(gc1), .out_valid(out_valid), .out_ready(out_ready),
    .out_c_0(out_c_0), .out_c_1(out_c_1), .fault(fault), .fault_cnt(fault_cnt),
    .busy(busy)
  );

  cini_mul_sequencer #(.REP(3), .CNT_W(4), .FAULT_ZERO(1'b0)) dut_fz0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_a_0(in_a_0), .in_a_1(in_a_1), .in_b_0(in_b_0), .in_b_1(in_b_1),
    .rnd_valid(rnd_valid), .rnd_ready(z_rnd_ready), .rnd_data(rnd_data),
    .gad_a_0(z_gad_a_0), .gad_a_1(z_gad_a_1), .gad_b_0(z_gad_b_0), .gad_b_1(z_gad_b_1),
    .gad_rand_ref(z_gad_rand_ref), .gad_rand_mul(z_gad_rand_mul),
    .gad_c_0(gc0), .gad_c_1(gc1), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_c_0(z_out_c_0), .out_c_1(z_out_c_1), .fault(z_fault), .fault_cnt(z_fault_cnt),
    .busy(z_busy)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected gadget drive n cycles after accept: b/ref in REF, a/mul in MUL.
  function automatic logic [13:0] exp_gad(input int n, input logic a0, a1, b0, b1,
                                          input logic [1:0] rnd);
    if (n == 1) return {6'b0, {3{b0}}, {3{b1}}, rnd[0], 1'b0};
    if (n == 2) return {{3{a0}}, {3{a1}}, 6'b0, 1'b0, rnd[1]};
    return 14'b0;
  endfunction

  task automatic do_op(input logic a0, a1, b0, b1, input logic [1:0] rnd,
                       input int stall, input int hold, input logic fi, output int rcyc);
    logic exp_c;
    logic [13:0] eg;
    logic oc0, oc1;
    int n;
    exp_c = (a0 ^ a1) & (b0 ^ b1);
    @(posedge clk); #1;
    in_a_0 = a0; in_a_1 = a1; in_b_0 = b0; in_b_1 = b1; rnd_data = rnd;
    in_valid = 1'b1; rnd_valid = (stall == 0); out_ready = (hold == 0); inj = fi;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk_val("stall_status", 32'({in_ready, rnd_ready, busy, z_in_ready, z_rnd_ready, z_busy}),
              32'(6'b010010));
      chk_val("stall_gad", 32'(gbus), 32'd0);
      @(posedge clk); #1;
      if (i == stall - 1) rnd_valid = 1'b1;
    end
    #1 chk_val("accept_ready", 32'({in_ready, rnd_ready}), 32'(2'b11));
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      eg = exp_gad(n, a0, a1, b0, b1, rnd);
      chk_val("gad", 32'(gbus), 32'(eg));
      chk_val("gad_fz0", 32'(zbus), 32'(eg));
      if (out_valid) break;
    end
    chk_val("latency", 32'(n), 32'd4);
    rcyc = cyc;
    if (fi) begin
      tb_fault = 1'b1;
      if (tb_cnt < 15) tb_cnt++;
    end
    chk_val("valid_fz0", 32'(z_out_valid), 32'd1);
    if (tb_fault) chk_val("c_forced_zero", 32'({out_c_0, out_c_1}), 32'd0);
    else          chk_val("c", 32'(out_c_0 ^ out_c_1), 32'(exp_c));
    chk_val("c_fz0", 32'(z_out_c_0 ^ z_out_c_1), 32'(exp_c));
    chk_val("fault", 32'({fault, fault_cnt}), 32'({tb_fault, 4'(tb_cnt)}));
    chk_val("fault_fz0", 32'({z_fault, z_fault_cnt}), 32'({tb_fault, 4'(tb_cnt)}));
    oc0 = out_c_0; oc1 = out_c_1;
    if (hold > 0) begin
      rnd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk_val("hold", 32'({out_valid, out_c_0, out_c_1, in_ready, busy}),
                32'({1'b1, oc0, oc1, 1'b0, 1'b1}));
      end
      rnd_valid = 1'b0;
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_val("release", 32'({busy, out_valid}), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int rc, prev;
    logic [5:0] v;
    reset = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    in_a_0 = 1'b0; in_a_1 = 1'b0; in_b_0 = 1'b0; in_b_1 = 1'b0; rnd_data = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("reset_ctl", 32'({out_valid, out_c_0, out_c_1, fault, fault_cnt, busy}), 32'd0);
    chk_val("reset_gad", 32'(gbus), 32'd0);
    reset = 1'b0;

    // Directed first case, then every share combination with every rnd word.
    do_op(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 0, 0, 1'b0, rc);
    for (int k = 0; k < 64; k++) begin
      v = 6'(k);
      do_op(v[0], v[1], v[2], v[3], v[5:4], 0, 0, 1'b0, rc);
    end

    // Consumer stalls the result for six cycles.
    v = 6'($urandom);
    do_op(v[0], v[1], v[2], v[3], v[5:4], 0, 6, 1'b0, rc);

    // PRNG not ready for three cycles.
    v = 6'($urandom);
    do_op(v[0], v[1], v[2], v[3], v[5:4], 3, 0, 1'b0, rc);

    // Back-to-back operations: five-cycle period.
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      v = 6'($urandom);
      do_op(v[0], v[1], v[2], v[3], v[5:4], 0, 0, 1'b0, rc);
      if (k > 0) chk_val("period", 32'(rc - prev), 32'd5);
      prev = rc;
    end

    // Fault injection, running the counter into saturation, then a clean op.
    for (int k = 0; k < 17; k++) begin
      v = 6'($urandom);
      do_op(v[0], v[1], v[2], v[3], v[5:4], 0, 0, 1'b1, rc);
    end
    v = 6'($urandom);
    do_op(v[0], v[1], v[2], v[3], v[5:4], 0, 0, 1'b0, rc);

    // Reset during MUL aborts the operation.
    @(posedge clk); #1;
    in_a_0 = 1'b1; in_a_1 = 1'b0; in_b_0 = 1'b1; in_b_1 = 1'b0; rnd_data = 2'b11;
    in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1; inj = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_val("mul_gad", 32'(gbus), 32'(exp_gad(2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11)));
    #1 reset = 1'b1;
    #1;
    chk_val("rst_gad", 32'(gbus), 32'd0);
    chk_val("rst_ctl", 32'({out_valid, busy, fault, fault_cnt}), 32'd0);
    tb_fault = 1'b0; tb_cnt = 0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_val("after_rst_idle", 32'({out_valid, busy}), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      v = 6'($urandom);
      do_op(v[0], v[1], v[2], v[3], v[5:4], 0, 0, 1'b0, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
